// File: rtl/sonic_echo_model.sv
// HC-SR04 sensor-side responder: answers a trig pulse with an echo whose width
// encodes the programmed target distance.
module sonic_echo_model #(
    parameter int unsigned CLK_PER_US  = 100,
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned MIN_CM      = 2,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [19:0] distance_cm,
    output logic        echo,
    output logic        busy,
    output logic        trig_err,
    output logic        meas_done
);

    // state     | meaning
    // IDLE      | waiting for a fresh trig rise
    // TRIG_HI   | measuring trig high time
    // BURST     | emulated 40 kHz burst before echo
    // ECHO      | echo high for the latched width
    // HOLDOFF   | dead time, trig ignored
    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    localparam logic [31:0] TRIG_CYC    = 32'(TRIG_MIN_US * CLK_PER_US);
    localparam logic [31:0] BURST_CYC   = 32'(BURST_US * CLK_PER_US);
    localparam logic [31:0] HOLD_CYC    = 32'(HOLDOFF_US * CLK_PER_US);
    localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_US * CLK_PER_US);
    localparam logic [31:0] ECHO_PER_CM = 32'(US_PER_CM * CLK_PER_US);
    localparam logic [31:0] MIN_D       = 32'(MIN_CM);
    localparam logic [31:0] MAX_D       = 32'(MAX_CM);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] echo_cyc_q, echo_cyc_d;
    logic        echo_q, echo_d;
    logic        trig_err_q, trig_err_d;
    logic        meas_done_q, meas_done_d;
    logic        sync1_q, trig_s_q, trig_d_q;
    logic        rise, fall;

    logic [31:0] dist_w, d_clamped, echo_cyc_calc;

    assign dist_w        = {12'd0, distance_cm};
    assign d_clamped     = (dist_w < MIN_D) ? MIN_D : dist_w;
    assign echo_cyc_calc = (dist_w > MAX_D) ? TIMEOUT_CYC : d_clamped * ECHO_PER_CM;

    assign rise = trig_s_q & ~trig_d_q;
    assign fall = ~trig_s_q & trig_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_d_q    <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            echo_cyc_q  <= '0;
            echo_q      <= 1'b0;
            trig_err_q  <= 1'b0;
            meas_done_q <= 1'b0;
        end else begin
            sync1_q     <= trig;
            trig_s_q    <= sync1_q;
            trig_d_q    <= trig_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            echo_cyc_q  <= echo_cyc_d;
            echo_q      <= echo_d;
            trig_err_q  <= trig_err_d;
            meas_done_q <= meas_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 32'd1;
        echo_cyc_d  = echo_cyc_q;
        echo_d      = echo_q;
        trig_err_d  = 1'b0;
        meas_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rise) state_d = S_TRIG_HI;
            end
            S_TRIG_HI: begin
                // The rise cycle is spent entering this state, so cnt lags the
                // synchronized high time by one.
                if (fall) begin
                    cnt_d = '0;
                    if (cnt_q >= TRIG_CYC - 32'd1) begin
                        echo_cyc_d = echo_cyc_calc;
                        state_d    = S_BURST;
                    end else begin
                        trig_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_BURST: begin
                if (cnt_q == BURST_CYC) begin
                    cnt_d   = '0;
                    echo_d  = 1'b1;
                    state_d = S_ECHO;
                end
            end
            S_ECHO: begin
                if (cnt_q == echo_cyc_q - 32'd1) begin
                    cnt_d       = '0;
                    echo_d      = 1'b0;
                    meas_done_d = 1'b1;
                    state_d     = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == HOLD_CYC - 32'd1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign echo      = echo_q;
    assign trig_err  = trig_err_q;
    assign meas_done = meas_done_q;
    assign busy      = (state_q == S_BURST) || (state_q == S_ECHO) || (state_q == S_HOLDOFF);

endmodule

// File: tb/tb_sonic_echo_model.sv
// Scoreboard bench for sonic_echo_model, run with one clock per microsecond so
// the long echo widths stay short in cycles.
module tb_sonic_echo_model;

    localparam int CPU     = 1;
    localparam int TRIG_C  = 10 * CPU;
    localparam int BURST_C = 200 * CPU;
    localparam int HOLD_C  = 100 * CPU;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic [19:0] distance_cm;
    logic        echo, busy, trig_err, meas_done;

    sonic_echo_model #(.CLK_PER_US(CPU)) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .distance_cm(distance_cm),
        .echo       (echo),
        .busy       (busy),
        .trig_err   (trig_err),
        .meas_done  (meas_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int rise;
        int width;
    } exp_t;

    exp_t q[$];
    int   bq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   echo_cnt = 0;
    int   md_cnt   = 0;
    int   te_cnt   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_width(input int d);
        if (d > 400) return 38000 * CPU;
        return ((d < 2) ? 2 : d) * 58 * CPU;
    endfunction

    // Monitor: echo rise/width and busy window against the queued expectations.
    initial begin
        bit prev_e = 1'b0;
        bit prev_b = 1'b0;
        int rise_c = 0;
        int brise_c = 0;
        exp_t e;
        int bw;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_e = 1'b0;
                prev_b = 1'b0;
            end else begin
                if (echo && !prev_e) begin
                    echo_cnt++;
                    rise_c = cyc;
                    if (q.size() == 0) check("unexpected_echo", 1, 0);
                    else check("rise_delay", 64'(cyc), 64'(q[0].rise));
                end
                if (!echo && prev_e && q.size() != 0) begin
                    e = q.pop_front();
                    check("echo_width", 64'(cyc - rise_c), 64'(e.width));
                    check("meas_done_at_fall", 64'(meas_done), 1);
                end
                if (busy && !prev_b) begin
                    brise_c = cyc;
                    if (bq.size() == 0) check("unexpected_busy", 1, 0);
                end
                if (!busy && prev_b && bq.size() != 0) begin
                    bw = bq.pop_front();
                    check("busy_width", 64'(cyc - brise_c), 64'(bw));
                end
                if (meas_done) md_cnt++;
                if (trig_err) te_cnt++;
                if (meas_done && trig_err) check("done_err_exclusive", 1, 0);
                prev_e = echo;
                prev_b = busy;
            end
        end
    end

    task automatic pulse(input int n, input int d, input bit valid);
        exp_t e;
        @(negedge clk);
        distance_cm = 20'(d);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
        if (valid) begin
            e.rise  = cyc + 4 + BURST_C;
            e.width = exp_width(d);
            q.push_back(e);
            bq.push_back(BURST_C + 1 + e.width + HOLD_C);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        repeat (4) @(negedge clk);
        while ((busy || q.size() != 0 || bq.size() != 0) && k < 100000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100000) check("idle_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_echo();
        int k = 0;
        while (!echo && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check("echo_timeout", 1, 0);
    endtask

    initial begin
        int e0, m0, t0;
        rst = 1'b1;
        trig = 1'b0;
        distance_cm = '0;
        #1;
        check("rst_echo", 64'(echo), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_trig_err", 64'(trig_err), 0);
        check("rst_meas_done", 64'(meas_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal 10 cm measurement
        pulse(TRIG_C, 10, 1'b1);
        wait_idle();
        check("meas_done_count", 64'(md_cnt), 1);

        // Short trig (one cycle below minimum), then clamped 1 cm
        t0 = te_cnt;
        e0 = echo_cnt;
        pulse(TRIG_C - 1, 10, 1'b0);
        repeat (20) @(negedge clk);
        check("short_trig_err_pulse", 64'(te_cnt - t0), 1);
        check("short_trig_no_echo", 64'(echo_cnt - e0), 0);
        pulse(TRIG_C, 1, 1'b1);
        wait_idle();

        // Range boundaries
        pulse(TRIG_C, 400, 1'b1);
        wait_idle();
        pulse(TRIG_C, 401, 1'b1);
        wait_idle();

        // Distance change in burst and retrigger in echo are ignored
        t0 = te_cnt;
        e0 = echo_cnt;
        pulse(TRIG_C, 10, 1'b1);
        repeat (50) @(negedge clk);
        distance_cm = 20'd100;
        wait_echo();
        repeat (10) @(negedge clk);
        trig = 1'b1;
        repeat (3) @(negedge clk);
        trig = 1'b0;
        wait_idle();
        check("retrig_no_err", 64'(te_cnt - t0), 0);
        check("retrig_one_echo", 64'(echo_cnt - e0), 1);

        // Trig held high across holdoff end needs a fresh rise
        e0 = echo_cnt;
        pulse(TRIG_C, 10, 1'b1);
        wait_echo();
        trig = 1'b1;
        wait_idle();
        repeat (300) @(negedge clk);
        check("held_trig_not_busy", 64'(busy), 0);
        check("held_trig_one_echo", 64'(echo_cnt - e0), 1);
        trig = 1'b0;
        repeat (10) @(negedge clk);
        pulse(TRIG_C, 5, 1'b1);
        wait_idle();
        check("fresh_rise_echo", 64'(echo_cnt - e0), 2);

        // Async reset mid-echo, then a normal 20 cm measurement
        pulse(TRIG_C, 10, 1'b1);
        wait_echo();
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_echo", 64'(echo), 0);
        check("async_rst_busy", 64'(busy), 0);
        repeat (3) @(negedge clk);
        q.delete();
        bq.delete();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        m0 = md_cnt;
        pulse(TRIG_C, 20, 1'b1);
        wait_idle();
        check("post_rst_meas_done", 64'(md_cnt - m0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sonic_echo_model.md
Name: sonic_echo_model

Overview:
- Synthesizable HC-SR04 ultrasonic sensor responder: the sensor end of the trig/echo protocol.
- Accepts a trigger pulse and returns an echo pulse whose width encodes a programmed target distance, at 58 us per cm.
- Used for hardware-in-loop and simulation in place of the physical sensor, on the 100 MHz system clock.
- Drives the echo input of the team's distance-measurement logic.

Parameters:
- CLK_PER_US, 100, system clock cycles per microsecond.
- TRIG_MIN_US, 10, minimum trig high time for a valid request.
- BURST_US, 200, delay from trig fall to echo rise (emulates the 40 kHz burst).
- US_PER_CM, 58, echo microseconds per centimetre.
- MIN_CM, 2, smaller distances are clamped up to this value.
- MAX_CM, 400, larger distances are treated as "no object".
- TIMEOUT_US, 38000, echo width reported for "no object".
- HOLDOFF_US, 100, dead time after echo falls during which trig is ignored.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- trig, in, 1, trigger from controller; asynchronous, synchronized internally.
- distance_cm, in, 20, target distance in cm; sampled once per measurement.
- echo, out, 1, echo pulse to controller; registered.
- busy, out, 1, high in BURST, ECHO and HOLDOFF.
- trig_err, out, 1, one-cycle pulse when a trig pulse shorter than TRIG_MIN_US ends.
- meas_done, out, 1, one-cycle pulse in the cycle echo falls.

Behaviour:
- Reset (async, rst=1): echo=0, busy=0, trig_err=0, meas_done=0, state=IDLE, all counters 0, sync flops 0. Outputs go low immediately, including mid-echo.
- Input sync: trig passes through a 2-flop synchronizer plus one delay flop for edge detection (trig_s, trig_d).
  - rise = trig_s & ~trig_d; fall = ~trig_s & trig_d.
- Counting: one 32-bit cycle counter cnt, cleared on every state entry.
- Constants, all in clock cycles:
  - TRIG_CYC = TRIG_MIN_US*CLK_PER_US
  - BURST_CYC = BURST_US*CLK_PER_US
  - HOLD_CYC = HOLDOFF_US*CLK_PER_US
- Echo width ECHO_CYC, computed in 32-bit arithmetic:
  - d = max(distance_cm, MIN_CM).
  - If distance_cm > MAX_CM: ECHO_CYC = TIMEOUT_US*CLK_PER_US.
  - Else: ECHO_CYC = d*US_PER_CM*CLK_PER_US.
  - Latched into a register on the fall that leaves TRIG_HI. Later changes to distance_cm do not affect the measurement in flight.
- States:
  - IDLE: wait for rise, then go to TRIG_HI. A trig already high when IDLE is entered does not start a measurement; a fresh rise is required.
  - TRIG_HI: cnt counts cycles with trig_s high. On fall:
    - cnt >= TRIG_CYC: latch ECHO_CYC, go to BURST.
    - otherwise: pulse trig_err, go to IDLE.
  - BURST: after BURST_CYC cycles go to ECHO, setting echo=1 on that transition edge.
  - ECHO: echo held high for exactly ECHO_CYC cycles. Then echo=0, meas_done pulses in the same cycle, go to HOLDOFF.
  - HOLDOFF: after HOLD_CYC cycles go to IDLE.
- Timing: measured from the first clk edge that samples raw trig low, echo rises exactly 3 + BURST_CYC cycles later.
- Trig activity in BURST, ECHO and HOLDOFF is ignored: no error, no restart.
- trig_err and meas_done never assert simultaneously. Each is a single-cycle pulse.
- Boundaries:
  - distance_cm = MAX_CM gives a normal echo.
  - distance_cm = MAX_CM+1 gives the timeout width.
  - A trig pulse of exactly TRIG_CYC synchronized cycles is valid.

Test Plan:
- Defaults, distance_cm=10, trig high 10 us (1000 cycles) -> echo rises 20003 cycles after trig sampled low, stays high exactly 58000 cycles; meas_done pulses once; busy high from BURST entry through HOLDOFF (20000+58000+10000 cycles).
- trig high 5 us (500 cycles) -> trig_err one-cycle pulse, echo stays 0, busy stays 0; a following valid 10 us trig with distance_cm=1 -> echo width 11600 cycles (clamped to 2 cm).
- distance_cm=400 -> echo 2,320,000 cycles; distance_cm=401 -> echo 3,800,000 cycles.
- distance_cm changed from 10 to 100 during BURST, second trig pulse during ECHO -> echo width remains 58000 cycles, no second echo, no trig_err.
- trig held high continuously across HOLDOFF end -> no new measurement until trig falls and rises again.
- rst asserted mid-ECHO -> echo=0 and busy=0 asynchronously; after release, a valid trig with distance_cm=20 -> normal 116000-cycle echo.
